// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bank
//  Desc     : Single memory endpoint. Requests are queued in an in-order FIFO,
//             executed one at a time against a local word array, and answered
//             after a fixed delay through a valid/ready response port.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bank #(
    parameter int MEM_ADDR  = 0,
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NCORES    = 2,
    parameter int TXID_W    = 4,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DELAY = 2,
    parameter int SRC_W     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [SRC_W-1:0]  req_src,
    input  logic [TXID_W-1:0] req_txid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic [SRC_W-1:0]  rsp_dst,
    output logic [TXID_W-1:0] rsp_txid,
    output logic [7:0]        rsp_mem
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(REQ_DEPTH + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W + SRC_W + TXID_W;

    localparam logic [1:0]       c_idle  = 2'd0;
    localparam logic [1:0]       c_wait  = 2'd1;
    localparam logic [1:0]       c_resp  = 2'd2;
    localparam logic [CNT_W-1:0] c_full  = CNT_W'(REQ_DEPTH);
    localparam logic [PTR_W-1:0] c_last  = PTR_W'(REQ_DEPTH - 1);
    localparam logic [3:0]       c_delay = 4'(RSP_DELAY);
    localparam logic [32:0]      c_depth = 33'(DEPTH);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [ENT_W-1:0]  r_fifo [REQ_DEPTH];
    logic [DATA_W-1:0] r_mem  [DEPTH];

    logic              r_rsp_wr;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_data;
    logic [SRC_W-1:0]  r_rsp_dst;
    logic [TXID_W-1:0] r_rsp_txid;

    logic              w_push;
    logic              w_pop;
    logic [ENT_W-1:0]  w_head;
    logic              w_h_wr;
    logic [ADDR_W-1:0] w_h_addr;
    logic [DATA_W-1:0] w_h_data;
    logic [SRC_W-1:0]  w_h_src;
    logic [TXID_W-1:0] w_h_txid;
    logic [IDX_W-1:0]  w_idx;
    logic              w_oob;
    logic [DATA_W-1:0] w_rsp_data;

    // Ready depends only on occupancy, so a full FIFO never bypasses a pop.
    assign req_ready = (r_count < c_full);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == c_idle) && (r_count != '0);

    assign w_head = r_fifo[r_rptr];
    assign {w_h_wr, w_h_addr, w_h_data, w_h_src, w_h_txid} = w_head;

    // Range check uses the full address so high bits cannot alias into the array.
    assign w_idx      = IDX_W'(w_h_addr);
    assign w_oob      = (33'(w_h_addr) >= c_depth);
    assign w_rsp_data = w_oob ? '0 : (w_h_wr ? w_h_data : r_mem[w_idx]);

    assign rsp_valid = (r_state == c_resp);
    assign rsp_wr    = r_rsp_wr;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign rsp_dst   = r_rsp_dst;
    assign rsp_txid  = r_rsp_txid;
    assign rsp_mem   = 8'(MEM_ADDR);

    // FIFO payload storage; occupancy tracking makes a reset here unnecessary.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {req_wr, req_addr, req_data, req_src, req_txid};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Execute/delay/respond sequencer; response fields are frozen at execute time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_idle;
            r_cnt      <= '0;
            r_rsp_wr   <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_dst  <= '0;
            r_rsp_txid <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_pop) begin
                        r_rsp_wr   <= w_h_wr;
                        r_rsp_err  <= w_oob;
                        r_rsp_data <= w_rsp_data;
                        r_rsp_dst  <= w_h_src;
                        r_rsp_txid <= w_h_txid;
                        r_cnt      <= c_delay;
                        r_state    <= (c_delay == 4'd0) ? c_resp : c_wait;
                    end
                end
                c_wait: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= c_resp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_resp: begin
                    if (rsp_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Word array; out-of-range writes are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_pop && w_h_wr && !w_oob) begin
            r_mem[w_idx] <= w_h_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bank
//  Desc     : Scoreboard bench for mem_bank. Instance a uses RSP_DELAY=2,
//             instance b uses RSP_DELAY=0 with four cores.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bank;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance a
    logic        a_req_valid = 0, a_req_ready, a_req_wr = 0;
    logic [7:0]  a_req_addr = 0;
    logic [31:0] a_req_data = 0;
    logic [0:0]  a_req_src = 0;
    logic [3:0]  a_req_txid = 0;
    logic        a_rsp_valid, a_rsp_ready = 0, a_rsp_wr, a_rsp_err;
    logic [31:0] a_rsp_data;
    logic [0:0]  a_rsp_dst;
    logic [3:0]  a_rsp_txid;
    logic [7:0]  a_rsp_mem;

    // instance b
    logic        b_req_valid = 0, b_req_ready, b_req_wr = 0;
    logic [7:0]  b_req_addr = 0;
    logic [31:0] b_req_data = 0;
    logic [1:0]  b_req_src = 0;
    logic [3:0]  b_req_txid = 0;
    logic        b_rsp_valid, b_rsp_ready = 0, b_rsp_wr, b_rsp_err;
    logic [31:0] b_rsp_data;
    logic [1:0]  b_rsp_dst;
    logic [3:0]  b_rsp_txid;
    logic [7:0]  b_rsp_mem;

    mem_bank #(.MEM_ADDR(5), .RSP_DELAY(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
        .req_addr(a_req_addr), .req_data(a_req_data), .req_src(a_req_src),
        .req_txid(a_req_txid),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_wr(a_rsp_wr),
        .rsp_err(a_rsp_err), .rsp_data(a_rsp_data), .rsp_dst(a_rsp_dst),
        .rsp_txid(a_rsp_txid), .rsp_mem(a_rsp_mem)
    );

    mem_bank #(.MEM_ADDR(9), .NCORES(4), .RSP_DELAY(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_addr(b_req_addr), .req_data(b_req_data), .req_src(b_req_src),
        .req_txid(b_req_txid),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_wr(b_rsp_wr),
        .rsp_err(b_rsp_err), .rsp_data(b_rsp_data), .rsp_dst(b_rsp_dst),
        .rsp_txid(b_rsp_txid), .rsp_mem(b_rsp_mem)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] data;
        logic [1:0]  dst;
        logic [3:0]  txid;
        int          acc;
        bit          lat;
        bit          gap;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [31:0] ma [16];
    logic [31:0] mb [16];
    bit a_lat = 0, b_gap = 0;
    bit a_prev_v = 0;
    int a_rise = 0, b_last_hs = 0;

    // Reference behaviour: serialized in-order execution lets the model update
    // memory at acceptance time.
    always @(negedge clk) begin
        if (rst) begin
            a_prev_v = 0;
        end else begin
            if (a_rsp_valid && !a_prev_v) a_rise = cyc;
            if (a_rsp_valid && a_rsp_ready) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_rsp", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    check("a_wr", a_rsp_wr, ea.wr);
                    check("a_err", a_rsp_err, ea.err);
                    check("a_data", a_rsp_data, ea.data);
                    check("a_dst", a_rsp_dst, ea.dst[0]);
                    check("a_txid", a_rsp_txid, ea.txid);
                    // accept edge -> rsp_valid seen: RSP_DELAY+2 sample cycles
                    if (ea.lat) check("a_latency", a_rise - ea.acc, 4);
                end
            end
            if (a_req_valid && a_req_ready) begin
                ea.wr   = a_req_wr;
                ea.err  = (a_req_addr >= 8'd16);
                ea.data = ea.err ? 32'd0 : (a_req_wr ? a_req_data : ma[a_req_addr[3:0]]);
                if (a_req_wr && !ea.err) ma[a_req_addr[3:0]] = a_req_data;
                ea.dst  = {1'b0, a_req_src};
                ea.txid = a_req_txid;
                ea.acc  = cyc;
                ea.lat  = a_lat;
                ea.gap  = 0;
                qa.push_back(ea);
            end
            a_prev_v = a_rsp_valid;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_rsp_valid && b_rsp_ready) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_rsp", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    check("b_wr", b_rsp_wr, eb.wr);
                    check("b_err", b_rsp_err, eb.err);
                    check("b_data", b_rsp_data, eb.data);
                    check("b_dst", b_rsp_dst, eb.dst);
                    check("b_txid", b_rsp_txid, eb.txid);
                    if (eb.gap) check("b_gap", cyc - b_last_hs, 2);
                end
                b_last_hs = cyc;
            end
            if (b_req_valid && b_req_ready) begin
                eb.wr   = b_req_wr;
                eb.err  = (b_req_addr >= 8'd16);
                eb.data = eb.err ? 32'd0 : (b_req_wr ? b_req_data : mb[b_req_addr[3:0]]);
                if (b_req_wr && !eb.err) mb[b_req_addr[3:0]] = b_req_data;
                eb.dst  = b_req_src;
                eb.txid = b_req_txid;
                eb.acc  = cyc;
                eb.lat  = 0;
                eb.gap  = b_gap;
                qb.push_back(eb);
            end
        end
    end

    // Holds the request up to 'bound' cycles; returns whether it was taken.
    task automatic send(input bit z, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [1:0] src,
                        input logic [3:0] txid, input int bound, output bit ok);
        if (z) begin
            b_req_valid = 1; b_req_wr = wr; b_req_addr = addr;
            b_req_data = data; b_req_src = src; b_req_txid = txid;
        end else begin
            a_req_valid = 1; a_req_wr = wr; a_req_addr = addr;
            a_req_data = data; a_req_src = src[0]; a_req_txid = txid;
        end
        ok = 0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            ok = z ? b_req_ready : a_req_ready;
            @(posedge clk);
            #1;
        end
        a_req_valid = 0;
        b_req_valid = 0;
    endtask

    task automatic put(input bit z, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [1:0] src, input logic [3:0] txid);
        bit ok;
        send(z, wr, addr, data, src, txid, 50, ok);
        check("req_accepted", ok, 1);
    endtask

    task automatic drain(input bit z);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((z ? qb.size() : qa.size()) == 0) break;
        end
        check("drain_empty", z ? qb.size() : qa.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_valid();
        bit seen;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = a_rsp_valid;
        end
        check("a_valid_timeout", seen, 1);
    endtask

    logic [43:0] snap;
    bit ok6;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        #1 rst = 1;
        #2;
        check("rst_req_ready", a_req_ready, 1);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_fields", {a_rsp_wr, a_rsp_err, a_rsp_dst, a_rsp_txid, a_rsp_data}, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        check("a_rsp_mem", a_rsp_mem, 5);
        check("b_rsp_mem", b_rsp_mem, 9);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        a_rsp_ready = 1;
        b_rsp_ready = 1;

        // write then read, with latency on the write
        a_lat = 1;
        put(0, 1, 3, 32'hDEADBEEF, 1, 1);
        a_lat = 0;
        put(0, 0, 3, 32'h0, 0, 2);
        drain(0);

        // backpressure: fields frozen for 10 cycles
        a_rsp_ready = 0;
        put(0, 0, 3, 32'h0, 1, 3);
        wait_a_valid();
        snap = {a_rsp_valid, a_rsp_wr, a_rsp_err, a_rsp_dst, a_rsp_txid, a_rsp_data, 4'h0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_stable", {a_rsp_valid, a_rsp_wr, a_rsp_err, a_rsp_dst, a_rsp_txid, a_rsp_data, 4'h0}, snap);
        end
        @(posedge clk);
        #1 a_rsp_ready = 1;
        drain(0);

        // full FIFO: one executing, four queued, sixth refused
        a_rsp_ready = 0;
        for (int i = 0; i < 5; i++)
            put(0, 1, 8'(8 + i), 32'h1000 + i, 2'(i), 4'(i));
        @(negedge clk);
        check("full_req_ready", a_req_ready, 0);
        @(posedge clk);
        #1;
        send(0, 0, 8, 0, 0, 5, 6, ok6);
        check("full_6th_refused", ok6, 0);
        a_rsp_ready = 1;
        drain(0);

        // out of range read and write, then sweep all words
        put(0, 0, 20, 32'h0, 0, 6);
        put(0, 1, 20, 32'hFFFFFFFF, 1, 7);
        for (int i = 0; i < 16; i++)
            put(0, 0, 8'(i), 32'h0, 2'(i), 4'(i));
        drain(0);

        // reset mid-operation: blocker answered, then 3 queued + 1 in WAIT
        a_rsp_ready = 0;
        put(0, 1, 5, 32'h12345678, 1, 7);
        wait_a_valid();
        @(posedge clk);
        #1;
        put(0, 0, 3, 32'h0, 0, 8);
        put(0, 0, 5, 32'h0, 1, 9);
        put(0, 0, 9, 32'h0, 0, 10);
        a_rsp_ready = 1;
        put(0, 0, 0, 32'h0, 1, 11);
        a_rsp_ready = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        check("arst_rsp_valid", a_rsp_valid, 0);
        check("arst_req_ready", a_req_ready, 1);
        check("arst_rsp_txid", a_rsp_txid, 0);
        check("arst_rsp_data", a_rsp_data, 0);
        qa.delete();
        qb.delete();
        for (int i = 0; i < 16; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        a_rsp_ready = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_stale_rsp", a_rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        put(0, 0, 5, 32'h0, 0, 12);
        put(0, 0, 3, 32'h0, 1, 13);
        drain(0);

        // RSP_DELAY=0 streaming: one response every 2 cycles
        for (int i = 0; i < 4; i++)
            put(1, 1, 8'(i), 32'hB000_0000 + 32'h1111 * i, 2'(3 - i), 4'(i));
        drain(1);
        for (int i = 0; i < 8; i++) begin
            b_gap = (i > 0);
            put(1, 0, 8'(i % 4), 32'h0, 2'(i), 4'(8 + i));
        end
        b_gap = 0;
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_bank.md
# mem_bank

Memory endpoint that sits directly downstream of the transaction-buffer pool on the read path (one instance per memory address). It accepts read/write requests through a valid/ready handshake and buffers them in an in-order request FIFO. Each request is executed against a local word array. After a fixed response delay, a response is returned upstream toward the write path through a second valid/ready handshake.

## Interface
- MEM_ADDR, 0: this bank's memory index; echoed on rsp_mem.
- DEPTH, 16: number of data words, 2..256.
- DATA_W, 32: data word width.
- ADDR_W, 8: request address width; the word index is req_addr.
- NCORES, 2: number of cores; sets SRC_W = $clog2(NCORES), minimum 1.
- TXID_W, 4: transaction-ID width.
- REQ_DEPTH, 4: request FIFO entries, at least 1.
- RSP_DELAY, 2: wait cycles between execution and response, 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  a request is offered.
- req_ready  out  1  the bank can accept the request.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_data  in  DATA_W  write data.
- req_src  in  SRC_W  originating core.
- req_txid  in  TXID_W  transaction ID.
- rsp_valid  out  1  a response is offered.
- rsp_ready  in  1  the downstream stage accepts the response.
- rsp_wr  out  1  echo of req_wr.
- rsp_err  out  1  address was out of range.
- rsp_data  out  DATA_W  read data; for writes, the data written.
- rsp_dst  out  SRC_W  echo of req_src.
- rsp_txid  out  TXID_W  echo of req_txid.
- rsp_mem  out  $clog2(NMEMS-compatible) 8  constant MEM_ADDR.

## Operation
- Request accept: a request is taken on any rising edge where req_valid && req_ready. It is pushed into the FIFO as {wr, addr, data, src, txid}.
- req_ready = (fifo_count < REQ_DEPTH). It does not depend on req_valid or on a pop in the same cycle, so there is no full-FIFO bypass.
- FSM states:
  - IDLE: if fifo_count > 0, pop the head and execute it on this edge. Go to WAIT with cnt = RSP_DELAY, or go straight to RESP if RSP_DELAY = 0.
  - WAIT: decrement cnt each cycle. When cnt reaches 1, go to RESP on that edge.
  - RESP: hold rsp_valid = 1 with stable fields. On rsp_ready, go to IDLE.
- Execute:
  - idx = req_addr. If idx >= DEPTH: rsp_err = 1, rsp_data = 0, and no array write.
  - Read: rsp_data = mem[idx].
  - Write: mem[idx] <= data, and rsp_data = data.
  - Response fields are latched into the response register at execute time.
- Ordering: responses leave strictly in acceptance order. Only one request is in execution at a time.
- A push and a pop on the same edge are both honoured; the count is unchanged.
- A write followed by a read to the same address returns the new data, because execution is serialized.

## Timing
- Reset (async assert, sync behaviour on deassert):
  - FSM goes to IDLE.
  - fifo_count = 0; req_ready = 1.
  - rsp_valid = 0, with rsp_wr, rsp_err, rsp_data, rsp_dst and rsp_txid all 0.
  - Every mem word = 0.
  - Requests queued or in flight at reset are dropped; no response is ever produced for them.
- Latency, for an empty FIFO and FSM in IDLE:
  - Accept at edge t.
  - Pop and execute at edge t+1.
  - rsp_valid is high after edge t+1+RSP_DELAY, i.e. RSP_DELAY=0 gives rsp_valid in the cycle after edge t+1.
- Back-to-back throughput with rsp_ready held high is one response per RSP_DELAY+2 cycles. The cycles are: IDLE pop, RSP_DELAY WAIT cycles, and one RESP cycle.
- rsp_valid must not drop, and response fields must not change, until rsp_ready is seen.
- Wrap-around: FIFO pointers wrap modulo REQ_DEPTH. The WAIT counter is 4 bits wide and never wraps.

## Test plan
- Write then read: RSP_DELAY=2. Write addr 3 = 0xDEADBEEF with txid 1, then read addr 3 with txid 2. Required responses:
  - {wr=1, data=0xDEADBEEF, txid=1}, with rsp_valid rising 3 cycles after acceptance.
  - Then {wr=0, data=0xDEADBEEF, txid=2}.
- Full FIFO: hold rsp_ready=0 and push 6 requests.
  - 1 request executes and REQ_DEPTH=4 are queued; req_ready=0 after the 5th acceptance.
  - Releasing rsp_ready drains all 5 responses in order, with txids 0..4.
- Out of range: DEPTH=16, read addr 20. Required response: rsp_err=1, rsp_data=0.
  - A write to addr 20 returns rsp_err=1 and leaves all 16 words unchanged.
- Backpressure stability: hold rsp_ready low for 10 cycles while rsp_valid is high. All rsp_* fields must stay constant for those 10 cycles.
- Reset mid-operation: with 3 requests queued and one in WAIT, assert rst asynchronously between edges.
  - Outputs must immediately show rsp_valid=0 and req_ready=1.
  - After deassert, no stale responses appear, and a read of the previously written address returns 0.
- RSP_DELAY=0: with rsp_ready=1, stream 8 reads. Required: one response every 2 cycles, with correct src/txid echo on every response.
